// File: rtl/aer_out_handshake_pkg.sv
// Shared AER definitions for the SNN accelerator output path.
package pa_SnnAccelerator;

  localparam int AER_ADDR_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    REQ_HI = 2'd2,
    ACK_LO = 2'd3
  } aer_state_e;

endpackage

// File: rtl/aer_out_handshake_fifo.sv
// Spike-event buffer: power-of-two ring with a combinational head and an occupancy count.
module aer_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8,
  localparam int PW   = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty,
  output logic [PW:0]  count
);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic          push_ok, pop_ok;

  assign full    = (count == (PW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // Pointers are exactly PW bits wide, so wrap modulo DEPTH is free.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/aer_out_handshake.sv
// Output-spike AER sender: buffers core spikes and emits them over a 4-phase REQ/ACK link,
// also latching the first spike of each classification window.
module aer_out_handshake
  import pa_SnnAccelerator::*;
#(
  parameter int FIFO_DEPTH  = 4,
  parameter int ADDR_W      = AER_ADDR_WIDTH,
  parameter int SYNC_STAGES = 2
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              SPK_VALID,
  input  logic [ADDR_W-1:0] SPK_ADDR,
  output logic              SPK_READY,
  input  logic              CLR_FIRST,
  output logic              AEROUT_REQ,
  input  logic              AEROUT_ACK,
  output logic [ADDR_W-1:0] AEROUT_ADDR,
  output logic              FIFO_FULL,
  output logic              FIRST_SPK_VALID,
  output logic [ADDR_W-1:0] FIRST_SPK_ADDR
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || SYNC_STAGES < 2) begin : g_bad_param
    $error("aer_out_handshake: FIFO_DEPTH must be a power of two >= 2, SYNC_STAGES >= 2");
  end

  logic              push, pop;
  logic              fifo_full, fifo_empty;
  logic [ADDR_W-1:0] head;
  logic [CW-1:0]     occ_unused;  // fill level, left for debug visibility

  assign SPK_READY = !fifo_full;
  assign FIFO_FULL = fifo_full;
  assign push      = SPK_VALID && SPK_READY;

  aer_fifo #(.DEPTH(FIFO_DEPTH), .W(ADDR_W)) u_fifo (
    .clk   (CLK),
    .rst   (RST),
    .push  (push),
    .wdata (SPK_ADDR),
    .pop   (pop),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (occ_unused)
  );

  // ACK comes from off-chip with no timing relation to CLK.
  logic [SYNC_STAGES-1:0] ack_sync;
  logic                   ack_s;

  always_ff @(posedge CLK) begin
    if (RST) ack_sync <= '0;
    else     ack_sync <= {ack_sync[SYNC_STAGES-2:0], AEROUT_ACK};
  end
  assign ack_s = ack_sync[SYNC_STAGES-1];

  aer_state_e        state_q, state_d;
  logic              req_d;
  logic [ADDR_W-1:0] addr_d;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= IDLE;
      AEROUT_REQ  <= 1'b0;
      AEROUT_ADDR <= '0;
    end else begin
      state_q     <= state_d;
      AEROUT_REQ  <= req_d;
      AEROUT_ADDR <= addr_d;
    end
  end

  // Address is loaded only on the IDLE pop, so it holds for the whole handshake.
  always_comb begin
    state_d = state_q;
    req_d   = AEROUT_REQ;
    addr_d  = AEROUT_ADDR;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          addr_d  = head;
          state_d = SETUP;
        end
      end
      SETUP: begin
        req_d   = 1'b1;
        state_d = REQ_HI;
      end
      REQ_HI: begin
        if (ack_s) begin
          req_d   = 1'b0;
          state_d = ACK_LO;
        end
      end
      ACK_LO: begin
        if (!ack_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // A clear coinciding with a push starts the new window with that push.
  always_ff @(posedge CLK) begin
    if (RST) begin
      FIRST_SPK_VALID <= 1'b0;
      FIRST_SPK_ADDR  <= '0;
    end else if (push && (CLR_FIRST || !FIRST_SPK_VALID)) begin
      FIRST_SPK_VALID <= 1'b1;
      FIRST_SPK_ADDR  <= SPK_ADDR;
    end else if (CLR_FIRST) begin
      FIRST_SPK_VALID <= 1'b0;
    end
  end

endmodule
